// File: rtl/store_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : store_trace_fifo
// Purpose  : Observes the CPU data-memory write bus and captures every store
//            whose address lies in [ADDR_LO, ADDR_HI]. Captured stores are
//            queued in a first-word-fall-through FIFO and drained over a
//            valid/ready stream. The CPU is never stalled: stores that hit a
//            full FIFO are dropped, flagged (overflow) and counted (drop_cnt).
// Ports    : clk, reset (async, active low), clear (sync flush)
//            mem_write / data_adr / write_data   - CPU store bus
//            out_valid / out_ready / out_addr / out_data / out_ts - drain
//            count, overflow, drop_cnt           - status
// Options  : STORE_TRACE_TIMESTAMP_EN - when defined, every entry carries the
//            TS_W-bit cycle-counter value of its capture cycle on out_ts;
//            otherwise no counter is built and out_ts reads 0.
// Revision : 1.0 - initial release
// ============================================================================
module store_trace_fifo #(
    parameter int unsigned DEPTH   = 16,
    parameter logic [31:0] ADDR_LO = 32'h0000_0000,
    parameter logic [31:0] ADDR_HI = 32'hFFFF_FFFF,
    parameter int unsigned TS_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     mem_write,
    input  logic [31:0]              data_adr,
    input  logic [31:0]              write_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_addr,
    output logic [31:0]              out_data,
    output logic [TS_W-1:0]          out_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned c_PTR_W = $clog2(DEPTH);
    localparam int unsigned c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    // Elaboration-time guard on the FIFO geometry.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("store_trace_fifo: DEPTH must be a power of 2 and at least 2");
    end

    // ------------------------------------------------------------------------
    // Address window. The borrow bit of a 33-bit subtraction gives an unsigned
    // compare that stays well-formed when the window spans the full range.
    // ------------------------------------------------------------------------
    logic [32:0] w_lo_diff;
    logic [32:0] w_hi_diff;
    logic        w_hit;

    assign w_lo_diff = {1'b0, data_adr} - {1'b0, ADDR_LO};
    assign w_hi_diff = {1'b0, ADDR_HI}  - {1'b0, data_adr};
    assign w_hit     = mem_write && !w_lo_diff[32] && !w_hi_diff[32];

    // ------------------------------------------------------------------------
    // FIFO control state
    // ------------------------------------------------------------------------
    logic [c_PTR_W-1:0] r_wr_ptr_q,   w_wr_ptr_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q,   w_rd_ptr_d;
    logic [c_CNT_W-1:0] r_count_q,    w_count_d;
    logic               r_overflow_q, w_overflow_d;
    logic [7:0]         r_drop_cnt_q, w_drop_cnt_d;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_mem_we;

    assign w_empty = (r_count_q == '0);
    assign w_full  = (r_count_q == c_FULL);
    assign w_pop   = !w_empty && out_ready;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign w_push  = w_hit && (!w_full || w_pop);
    assign w_drop  = w_hit && w_full && !w_pop;
    // Nothing is captured in a clear cycle.
    assign w_mem_we = w_push && !clear;

    always_comb begin
        w_wr_ptr_d   = r_wr_ptr_q;
        w_rd_ptr_d   = r_rd_ptr_q;
        w_count_d    = r_count_q;
        w_overflow_d = r_overflow_q;
        w_drop_cnt_d = r_drop_cnt_q;

        if (clear) begin
            w_wr_ptr_d   = '0;
            w_rd_ptr_d   = '0;
            w_count_d    = '0;
            w_overflow_d = 1'b0;
            w_drop_cnt_d = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_d = r_wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                w_rd_ptr_d = r_rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   w_count_d = r_count_q + 1'b1;
                2'b01:   w_count_d = r_count_q - 1'b1;
                default: w_count_d = r_count_q;
            endcase
            if (w_drop) begin
                w_overflow_d = 1'b1;
                if (r_drop_cnt_q != 8'hFF) begin
                    w_drop_cnt_d = r_drop_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr_q   <= '0;
            r_rd_ptr_q   <= '0;
            r_count_q    <= '0;
            r_overflow_q <= 1'b0;
            r_drop_cnt_q <= '0;
        end else begin
            r_wr_ptr_q   <= w_wr_ptr_d;
            r_rd_ptr_q   <= w_rd_ptr_d;
            r_count_q    <= w_count_d;
            r_overflow_q <= w_overflow_d;
            r_drop_cnt_q <= w_drop_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Storage. Contents need no reset: an empty FIFO masks the outputs.
    // ------------------------------------------------------------------------
    logic [31:0] r_addr_mem [DEPTH];
    logic [31:0] r_data_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_addr_mem[r_wr_ptr_q] <= data_adr;
            r_data_mem[r_wr_ptr_q] <= write_data;
        end
    end

`ifdef STORE_TRACE_TIMESTAMP_EN
    // Free-running capture-cycle counter; zeroed by reset and by clear.
    logic [TS_W-1:0] r_ts_q, w_ts_d;
    logic [TS_W-1:0] r_ts_mem [DEPTH];

    always_comb begin
        w_ts_d = r_ts_q + 1'b1;
        if (clear) begin
            w_ts_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ts_q <= '0;
        end else begin
            r_ts_q <= w_ts_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_ts_mem[r_wr_ptr_q] <= r_ts_q;
        end
    end

    assign out_ts = w_empty ? '0 : r_ts_mem[r_rd_ptr_q];
`else
    assign out_ts = '0;
`endif

    // ------------------------------------------------------------------------
    // First-word-fall-through outputs, driven only by registered state.
    // ------------------------------------------------------------------------
    assign out_valid = !w_empty;
    assign out_addr  = w_empty ? 32'd0 : r_addr_mem[r_rd_ptr_q];
    assign out_data  = w_empty ? 32'd0 : r_data_mem[r_rd_ptr_q];
    assign count     = r_count_q;
    assign overflow  = r_overflow_q;
    assign drop_cnt  = r_drop_cnt_q;

endmodule
`default_nettype wire
